// File: rtl/adder_pkg.sv
// Shared types and parameter helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_steps(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder made of half-adder-pair full-adder cells.
// Zero latency, no handshake; sits inside the serial adder datapath.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] hs;
  logic [DIGIT-1:0] hc1;
  logic [DIGIT-1:0] hc2;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign hs[i]   = a[i] ^ b[i];
    assign hc1[i]  = a[i] & b[i];
    assign s[i]    = hs[i] ^ c[i];
    assign hc2[i]  = hs[i] & c[i];
    assign c[i+1]  = hc1[i] | hc2[i];
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH/DIGIT RUN cycles after acceptance, result held in DONE
// until out_ready; in_ready only in IDLE, so a stalled consumer blocks new operands.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = num_steps(WIDTH, DIGIT);
  localparam int CW = $clog2(N + 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_chk
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       sum_sh;
  logic                   carry_r;
  logic                   a_msb;
  logic                   b_msb;
  logic                   ovf_r;
  logic                   rdy_r;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       d_s;
  logic                   d_co;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_nxt;
  logic                   last_step;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sh[DIGIT-1:0]),
    .b  (b_sh[DIGIT-1:0]),
    .ci (carry_r),
    .s  (d_s),
    .co (d_co)
  );

  // New digit enters at the MSB end; works even when DIGIT == WIDTH.
  assign sum_cat   = {d_s, sum_sh};
  assign sum_nxt   = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step = (cnt == CW'(N - 1));

  // rdy_r keeps in_ready low through reset and the edge that releases it.
  assign in_ready  = rdy_r && (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry_r;
  assign overflow  = ovf_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last_step)            state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy_r   <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_r <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_r <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= cin;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          sum_sh  <= sum_nxt;
          carry_r <= d_co;
          cnt     <= cnt + CW'(1);
          if (last_step)
            ovf_r <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder across four WIDTH/DIGIT shapes sharing one handshake.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;

  logic [7:0]  s0, s1, s2;
  logic [15:0] s3;
  logic [15:0] sum_o  [4];
  logic        cout_o [4];
  logic        ovf_o  [4];
  logic        ov_o   [4];
  logic        ir_o   [4];

  localparam int WID [4] = '{8, 8, 8, 16};
  localparam int LAT [4] = '{8, 2, 1, 8};

  int n_cmp = 0;
  int n_err = 0;
  int lat [4];
  int got_n [4];
  bit sb_on = 1'b0;
  logic [17:0] exp_q [4][$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[0]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov_o[0]), .out_ready(out_ready),
    .sum(s0), .cout(cout_o[0]), .overflow(ovf_o[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov_o[1]), .out_ready(out_ready),
    .sum(s1), .cout(cout_o[1]), .overflow(ovf_o[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[2]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov_o[2]), .out_ready(out_ready),
    .sum(s2), .cout(cout_o[2]), .overflow(ovf_o[2]));
  serial_adder #(.WIDTH(16), .DIGIT(2)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[3]),
    .a(a), .b(b), .cin(cin), .out_valid(ov_o[3]), .out_ready(out_ready),
    .sum(s3), .cout(cout_o[3]), .overflow(ovf_o[3]));

  assign sum_o[0] = {8'h00, s0};
  assign sum_o[1] = {8'h00, s1};
  assign sum_o[2] = {8'h00, s2};
  assign sum_o[3] = s3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ref_res(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    logic [16:0] t;
    logic [15:0] m;
    logic [15:0] s;
    logic        co;
    logic        ov;
    m  = (w == 8) ? 16'h00FF : 16'hFFFF;
    t  = {1'b0, x & m} + {1'b0, y & m} + 17'(c);
    s  = t[15:0] & m;
    co = (w == 8) ? t[8] : t[16];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  function automatic bit all_ready();
    return ir_o[0] && ir_o[1] && ir_o[2] && ir_o[3];
  endfunction

  // Launch one operation on all instances and record each out_valid rise cycle.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input bit pulse);
    check("op_ready", 32'(all_ready()), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (pulse && cyc == 2) begin
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (ov_o[i] && lat[i] == 0) lat[i] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_all(input string name, input logic [15:0] e8, input logic c8,
                            input logic o8, input logic [15:0] e16, input logic c16,
                            input logic o16);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_u%0d_sum", name, i),  32'(sum_o[i]),  32'((i == 3) ? e16 : e8));
      check($sformatf("%s_u%0d_cout", name, i), 32'(cout_o[i]), 32'((i == 3) ? c16 : c8));
      check($sformatf("%s_u%0d_ovf", name, i),  32'(ovf_o[i]),  32'((i == 3) ? o16 : o8));
      check($sformatf("%s_u%0d_lat", name, i),  32'(lat[i]),    32'(LAT[i]));
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_u%0d_ov_low", name, i), 32'(ov_o[i]), 32'd0);
      check($sformatf("%s_u%0d_ir_high", name, i), 32'(ir_o[i]), 32'd1);
    end
  endtask

  // Scoreboard: acceptances and deliveries sampled mid-cycle, effective at the next edge.
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid && ir_o[i]) exp_q[i].push_back(ref_res(WID[i], a, b, cin));
        if (ov_o[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("sb_u%0d_extra", i), 32'd1, 32'd0);
          end else begin
            check($sformatf("sb_u%0d_res", i), 32'({ovf_o[i], cout_o[i], sum_o[i]}),
                  32'(exp_q[i].pop_front()));
            got_n[i]++;
          end
        end
      end
    end
  end

  initial begin
    int issued;
    int cycles;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_u%0d_ir", i),   32'(ir_o[i]),   32'd0);
      check($sformatf("rst_u%0d_ov", i),   32'(ov_o[i]),   32'd0);
      check($sformatf("rst_u%0d_sum", i),  32'(sum_o[i]),  32'd0);
      check($sformatf("rst_u%0d_cout", i), 32'(cout_o[i]), 32'd0);
      check($sformatf("rst_u%0d_ovf", i),  32'(ovf_o[i]),  32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ir", 32'(all_ready()), 32'd1);

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    expect_all("ff_01", 16'h00, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    release_out("ff_01");

    do_op(16'h007F, 16'h0001, 1'b0, 1'b0);
    expect_all("7f_01", 16'h80, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0);
    release_out("7f_01");

    do_op(16'h0080, 16'h0080, 1'b0, 1'b0);
    expect_all("80_80", 16'h00, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
    release_out("80_80");

    do_op(16'h00A5, 16'h005A, 1'b1, 1'b0);
    expect_all("a5_5a", 16'h00, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    release_out("a5_5a");

    // Backpressure with stray in_valid pulses during RUN and DONE
    do_op(16'h0070, 16'h0030, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = (k % 2) == 0;
      @(posedge clk); #1;
      check($sformatf("hold%0d_sum", k),  32'(sum_o[0]),  32'h00A0);
      check($sformatf("hold%0d_cout", k), 32'(cout_o[0]), 32'd0);
      check($sformatf("hold%0d_ovf", k),  32'(ovf_o[0]),  32'd1);
      check($sformatf("hold%0d_ov", k),   32'(ov_o[0]),   32'd1);
      check($sformatf("hold%0d_ir", k),   32'(ir_o[0]),   32'd0);
    end
    in_valid = 1'b0;
    expect_all("70_30", 16'hA0, 1'b0, 1'b1, 16'h00A0, 1'b0, 1'b0);
    release_out("70_30");

    // Reset at step 3 of the 8-step add
    a = 16'h0055; b = 16'h0011; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ir", 32'(ir_o[0]), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid_rst_u%0d_ov", i),  32'(ov_o[i]),  32'd0);
      check($sformatf("mid_rst_u%0d_sum", i), 32'(sum_o[i]), 32'd0);
      check($sformatf("mid_rst_u%0d_ir", i),  32'(ir_o[i]),  32'd1);
    end
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    expect_all("03_04", 16'h07, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    release_out("03_04");

    // Randomised stress with consumer stalls
    for (int i = 0; i < 4; i++) got_n[i] = 0;
    sb_on = 1'b1;
    issued = 0;
    cycles = 0;
    while (issued < 1000 && cycles < 60000) begin
      @(posedge clk); #1;
      cycles++;
      if (all_ready()) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        issued++;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    out_ready = 1'b0;
    sb_on = 1'b0;
    check("stress_issued", 32'(issued), 32'd1000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stress_u%0d_count", i), 32'(got_n[i]), 32'd1000);
      check($sformatf("stress_u%0d_left", i),  32'(exp_q[i].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
